// File: rtl/ps2_host_tx_if.sv
// Host-side signal bundle for the PS/2 command transmitter: request/status
// handshake plus the raw line levels and open-drain pull enables.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   modport master (
      output tx_data, tx_start, ps2_clk_in, ps2_data_in,
      input  ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error
   );

   modport slave (
      input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
      output ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibits the bus, issues a request-to-send,
// shifts out data/parity/stop on device clock falls and checks the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2700,
   parameter int TIMEOUT_CYCLES = 405000
) (
   input logic          clock_27mhz,
   input logic          reset_n,
   ps2_host_tx_if.slave bus
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       clk_sync_q, data_sync_q;
   logic             clk_prev_q;
   logic [7:0]       byte_q, byte_d;
   logic             parity_q, parity_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             drive_q, drive_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             clk_oe, data_oe;
   logic             clk_s, data_s, fall, timed_out, frame_bit;

   assign clk_s     = clk_sync_q[1];
   assign data_s    = data_sync_q[1];
   assign fall      = clk_prev_q & ~clk_s;
   assign timed_out = (to_cnt_q == TO_LAST);

   // Bit order on the wire after the start bit: data LSB first, odd parity, stop.
   always_comb begin
      frame_bit = 1'b1;
      if (bit_cnt_q < 4'd8)
         frame_bit = byte_q[bit_cnt_q[2:0]];
      else if (bit_cnt_q == 4'd8)
         frame_bit = parity_q;
   end

   always_ff @(posedge clock_27mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
         byte_q      <= '0;
         parity_q    <= 1'b0;
         bit_cnt_q   <= '0;
         inh_cnt_q   <= '0;
         to_cnt_q    <= '0;
         drive_q     <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk_in};
         data_sync_q <= {data_sync_q[0], bus.ps2_data_in};
         clk_prev_q  <= clk_s;
         byte_q      <= byte_d;
         parity_q    <= parity_d;
         bit_cnt_q   <= bit_cnt_d;
         inh_cnt_q   <= inh_cnt_d;
         to_cnt_q    <= to_cnt_d;
         drive_q     <= drive_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      byte_d    = byte_q;
      parity_d  = parity_q;
      bit_cnt_d = bit_cnt_q;
      inh_cnt_d = inh_cnt_q;
      to_cnt_d  = to_cnt_q;
      drive_d   = drive_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      clk_oe    = 1'b0;
      data_oe   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.tx_start) begin
               byte_d    = bus.tx_data;
               parity_d  = ~^bus.tx_data;
               inh_cnt_d = '0;
               state_d   = INHIBIT;
            end
         end
         INHIBIT: begin
            clk_oe = 1'b1;
            if (inh_cnt_q == INH_LAST)
               state_d = REQ;
            else
               inh_cnt_d = inh_cnt_q + 1'b1;
         end
         REQ: begin
            clk_oe    = 1'b1;
            data_oe   = 1'b1;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            drive_d   = 1'b1;
            state_d   = SHIFT;
         end
         SHIFT: begin
            data_oe = drive_q;
            if (fall) begin
               to_cnt_d  = '0;
               drive_d   = ~frame_bit;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 4'd9)
                  state_d = ACK;
            end else if (timed_out) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ACK: begin
            if (fall) begin
               to_cnt_d = '0;
               if (!data_s) begin
                  state_d = RELEASE;
               end else begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end else if (timed_out) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            // Device must let go of both lines before the bus is reused.
            if (clk_s && data_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (fall) begin
               to_cnt_d = '0;
            end else if (timed_out) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ps2_clk_oe  = clk_oe;
   assign bus.ps2_data_oe = data_oe;
   assign bus.tx_busy     = (state_q != IDLE);
   assign bus.tx_done     = done_q;
   assign bus.tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: an open-drain keyboard model clocks frames
// out of the host and a frame-level reference predicts bits and outcomes.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   localparam int INHIBIT_CYCLES = 2700;
   localparam int TIMEOUT_CYCLES = 1500;
   // Pin change to registered pulse: two synchronizer flops plus the edge register.
   localparam int EDGE_LAT = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;

   always #5 clk = ~clk;

   ps2_host_tx_if bus();

   // Wired-AND open-drain lines shared by host and keyboard model.
   assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
   assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INHIBIT_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clock_27mhz(clk),
      .reset_n    (reset_n),
      .bus        (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int err_cyc = 0;
   int last_fall_cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.tx_done) done_cnt++;
      if (bus.tx_error) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (bus.tx_done && bus.tx_error) both_cnt++;
   end

   // Expected wire frame: [7:0] data LSB first, [8] odd parity, [9] stop.
   function automatic logic [9:0] ref_frame(input logic [7:0] b);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) if (b[i]) ones++;
      ref_frame = {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_tx(input logic [7:0] b);
      bus.tx_data  = b;
      bus.tx_start = 1'b1;
      tick();
      bus.tx_start = 1'b0;
   endtask

   task automatic measure_inhibit(input string tag);
      int inh, rq, k;
      inh = 0; rq = 0; k = 0;
      while (!(!bus.ps2_clk_oe && bus.ps2_data_oe) && k < INHIBIT_CYCLES + 100) begin
         if (bus.ps2_clk_oe && !bus.ps2_data_oe) inh++;
         else if (bus.ps2_clk_oe && bus.ps2_data_oe) rq++;
         tick();
         k++;
      end
      check_eq({tag, "_inhibit_len"}, inh, INHIBIT_CYCLES);
      check_eq({tag, "_req_len"}, rq, 1);
      check_eq({tag, "_shift_entry"}, {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b01);
   endtask

   // Keyboard model: generates n falling/rising pairs, samples data on rises.
   task automatic kb_xfer(input int n_edges, input bit ack_low, input int hp,
                          output logic [9:0] rx);
      rx = '0;
      for (int i = 0; i < n_edges; i++) begin
         repeat (hp) tick();
         dev_clk = 1'b0;
         last_fall_cyc = cyc;
         repeat (hp) tick();
         if (i < 10) rx[i] = bus.ps2_data_in;
         dev_clk = 1'b1;
         if (i == 9 && ack_low) dev_data = 1'b0;
      end
      if (!dev_data) begin
         repeat (hp) tick();
         dev_data = 1'b1;
      end
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int k;
      k = 0;
      while (bus.tx_busy && k < bound) begin
         tick();
         k++;
      end
      check_eq({tag, "_idle"}, bus.tx_busy, 1'b0);
      repeat (2) tick();
   endtask

   task automatic send_and_check(input string tag, input logic [7:0] b,
                                 input bit ack_low, input int hp);
      int d0, e0;
      logic [9:0] rx;
      d0 = done_cnt; e0 = err_cnt;
      start_tx(b);
      check_eq({tag, "_busy"}, bus.tx_busy, 1'b1);
      measure_inhibit(tag);
      kb_xfer(11, ack_low, hp, rx);
      check_eq({tag, "_bits"}, rx, ref_frame(b));
      wait_idle(tag, 200);
      check_eq({tag, "_done"}, done_cnt - d0, ack_low ? 1 : 0);
      check_eq({tag, "_error"}, err_cnt - e0, ack_low ? 0 : 1);
      check_eq({tag, "_oe"}, {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] rx;
      int d0, e0;
      bus.tx_data  = 8'h00;
      bus.tx_start = 1'b0;
      repeat (3) tick();
      check_eq("rst_clk_oe",  bus.ps2_clk_oe,  1'b0);
      check_eq("rst_data_oe", bus.ps2_data_oe, 1'b0);
      check_eq("rst_busy",    bus.tx_busy,     1'b0);
      check_eq("rst_done",    bus.tx_done,     1'b0);
      check_eq("rst_error",   bus.tx_error,    1'b0);
      reset_n = 1'b1;
      repeat (3) tick();

      send_and_check("ed", 8'hED, 1'b1, 20);
      send_and_check("b00", 8'h00, 1'b1, 16);
      send_and_check("b01", 8'h01, 1'b1, 16);
      send_and_check("nack", 8'hA5, 1'b0, 18);

      // Device stops clocking after 4 bits.
      d0 = done_cnt; e0 = err_cnt;
      start_tx(8'h3C);
      measure_inhibit("tmo");
      kb_xfer(4, 1'b0, 15, rx);
      wait_idle("tmo", TIMEOUT_CYCLES + 200);
      check_eq("tmo_error", err_cnt - e0, 1);
      check_eq("tmo_done", done_cnt - d0, 0);
      check_eq("tmo_latency", err_cyc - last_fall_cyc, TIMEOUT_CYCLES + EDGE_LAT);
      check_eq("tmo_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);

      // Second request mid-shift must be dropped.
      d0 = done_cnt;
      start_tx(8'hC3);
      measure_inhibit("ign");
      fork
         kb_xfer(11, 1'b1, 18, rx);
         begin
            repeat (6 * 18) tick();
            bus.tx_data  = 8'h5A;
            bus.tx_start = 1'b1;
            tick();
            bus.tx_start = 1'b0;
         end
      join
      check_eq("ign_bits", rx, ref_frame(8'hC3));
      wait_idle("ign", 200);
      check_eq("ign_done", done_cnt - d0, 1);
      repeat (30) tick();
      check_eq("ign_no_queue", bus.tx_busy, 1'b0);

      // Asynchronous reset during SHIFT while the host is pulling data low.
      d0 = done_cnt; e0 = err_cnt;
      start_tx(8'h00);
      measure_inhibit("rst");
      kb_xfer(5, 1'b0, 15, rx);
      check_eq("rst_pre_drive", bus.ps2_data_oe, 1'b1);
      #3 reset_n = 1'b0;
      #1;
      check_eq("rst_mid_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b00);
      check_eq("rst_mid_busy", bus.tx_busy, 1'b0);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (5) tick();
      check_eq("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      send_and_check("f4", 8'hF4, 1'b1, 20);

      for (int r = 0; r < 4; r++) begin
         logic [7:0] b;
         int hp;
         bit ack;
         b   = 8'($urandom);
         hp  = $urandom_range(12, 25);
         ack = ($urandom_range(0, 3) != 0);
         send_and_check($sformatf("rnd%0d", r), b, ack, hp);
      end

      check_eq("done_error_overlap", both_cnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 2700, clock-low inhibit time in clock_27mhz cycles (100 us).
REQ-002 Parameter TIMEOUT_CYCLES, default 405000, max cycles between device clock falling edges (15 ms).
REQ-003 clock_27mhz  input  1  system clock; the block's only clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  8  command byte to send to the keyboard (e.g. 0xED set-LEDs).
REQ-006 tx_start  input  1  one-cycle request; accepted only in IDLE.
REQ-007 ps2_clk_in  input  1  raw PS/2 clock line level, asynchronous.
REQ-008 ps2_data_in  input  1  raw PS/2 data line level, asynchronous.
REQ-009 ps2_clk_oe  output  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-010 ps2_data_oe  output  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-011 tx_busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-012 tx_done  output  1  one-cycle pulse, transfer acknowledged by device.
REQ-013 tx_error  output  1  one-cycle pulse, NACK or timeout.

Function
REQ-014 ps2_clk_in and ps2_data_in shall pass through 2-flop synchronizers; a falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-015 States: IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE.
REQ-016 IDLE: both oe low; on tx_start latch tx_data, compute odd parity (parity bit = ~^tx_data), go INHIBIT.
REQ-017 tx_start while not IDLE shall be ignored; no queuing.
REQ-018 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-019 REQ: ps2_clk_oe=1 and ps2_data_oe=1 (start bit 0) for 1 cycle, then ps2_clk_oe=0, go SHIFT with bit counter 0.
REQ-020 SHIFT: on each device-clock falling edge, drive the next bit: counter 0-7 data LSB first, 8 parity, 9 stop (data released); ps2_data_oe = ~bit; counter increments per edge.
REQ-021 After stop bit driven, go ACK; ps2_data_oe=0 from then on.
REQ-022 ACK: on next falling edge sample synced data; 0 -> RELEASE; 1 -> tx_error pulse, IDLE.
REQ-023 RELEASE: wait until synced clock and data both 1, then tx_done pulse, IDLE.
REQ-024 Timeout counter resets on every falling edge and on entry to SHIFT; reaching TIMEOUT_CYCLES in SHIFT, ACK or RELEASE shall release both lines, pulse tx_error, go IDLE.
REQ-025 tx_done and tx_error shall never assert in the same cycle; each is exactly one cycle.
REQ-026 tx_busy shall be low only in IDLE.
REQ-027 Sequential logic shall use clock_27mhz alone; no logic is clocked by ps2_clk_in.

Reset
REQ-028 reset_n low shall immediately (asynchronously) force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0, counters 0, latched byte 0x00.
REQ-029 Reset mid-transfer shall abort without pulsing tx_done or tx_error; the first tx_start after release of reset shall be accepted normally.

Verification
REQ-030 tx_data=0xED, tx_start, keyboard model clocks 11 edges, ACK low -> clock held low 2700 cycles, bits 1,0,1,1,0,1,1,1, parity 1, stop 1, one tx_done pulse, no tx_error.
REQ-031 tx_data=0x00 then 0x01 -> parity bits 1 then 0 respectively; both tx_done.
REQ-032 Model leaves data high on ACK edge -> tx_error one cycle, tx_done never, both oe 0, IDLE.
REQ-033 Model stops clocking after 4 bits -> tx_error exactly TIMEOUT_CYCLES after last falling edge, lines released.
REQ-034 tx_start pulsed again during SHIFT -> ignored; transmitted bits match first byte only.
REQ-035 reset_n low during SHIFT -> both oe 0 same cycle, no pulses; next send of 0xF4 completes with tx_done.
